// File: rtl/des_decrypt_core.sv
// Iterative DES decryption: one Feistel round per clock, keys K16..K1 derived
// by rotating the PC-1 halves right from the unrotated load.

module des_sbox #(
  parameter logic [255:0] TABLE = '0
) (
  input  logic [5:0] addr,
  output logic [3:0] data
);
  // Row is {addr[5],addr[0]}, column addr[4:1]; entry 0 is the MSB nibble.
  logic [5:0] idx;
  logic [7:0] pos;

  assign idx  = {addr[5], addr[0], addr[4:1]};
  assign pos  = {~idx, 2'b00};
  assign data = TABLE[pos +: 4];
endmodule

module des_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [63:0] ciphertext,
  output logic        busy,
  output logic        done,
  output logic [63:0] plaintext
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUND = 1'b1;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam logic [255:0] SBOX_T [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  logic [0:0]  state;
  logic [3:0]  rnd;
  logic [31:0] l, r;
  logic [27:0] c, d;

  logic [63:0] ip_val, pre_out, pt_val;
  logic [55:0] pc1_val, cd_n;
  logic [27:0] c_n, d_n;
  logic [47:0] k_rnd, e_val, s_in;
  logic [31:0] s_out, f_val, r_next;
  logic        unused_parity;

  // Parity bits drop out in PC-1; folded here only so they are not dangling.
  assign unused_parity = ^{key[56], key[48], key[40], key[32],
                           key[24], key[16], key[8], key[0]};

  genvar g;
  for (g = 0; g < 64; g++) begin : g_ip_fp
    assign ip_val[63-g] = ciphertext[64-IP_T[g]];
    assign pt_val[63-g] = pre_out[64-FP_T[g]];
  end
  for (g = 0; g < 56; g++) begin : g_pc1
    assign pc1_val[55-g] = key[64-PC1_T[g]];
  end
  for (g = 0; g < 48; g++) begin : g_e_pc2
    assign e_val[47-g] = r[32-E_T[g]];
    assign k_rnd[47-g] = cd_n[56-PC2_T[g]];
  end
  for (g = 0; g < 32; g++) begin : g_p
    assign f_val[31-g] = s_out[32-P_T[g]];
  end
  for (g = 0; g < 8; g++) begin : g_sbox
    des_sbox #(.TABLE(SBOX_T[g])) u_sbox (
      .addr(s_in[47-6*g -: 6]),
      .data(s_out[31-4*g -: 4])
    );
  end

  // Reverse schedule: round 0 uses the loaded halves as-is (K16); later
  // rounds undo the forward left shifts in reverse order.
  always_comb begin
    c_n = c;
    d_n = d;
    case (rnd)
      4'd0: begin
        c_n = c;
        d_n = d;
      end
      4'd1, 4'd8, 4'd15: begin
        c_n = {c[0], c[27:1]};
        d_n = {d[0], d[27:1]};
      end
      default: begin
        c_n = {c[1:0], c[27:2]};
        d_n = {d[1:0], d[27:2]};
      end
    endcase
  end

  assign cd_n    = {c_n, d_n};
  assign s_in    = e_val ^ k_rnd;
  assign r_next  = l ^ f_val;
  assign pre_out = {r_next, r};
  assign busy    = (state == ROUND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      done      <= 1'b0;
      plaintext <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            l     <= ip_val[63:32];
            r     <= ip_val[31:0];
            c     <= pc1_val[55:28];
            d     <= pc1_val[27:0];
            rnd   <= '0;
            state <= ROUND;
          end
        end
        default: begin
          l   <= r;
          r   <= r_next;
          c   <= c_n;
          d   <= d_n;
          rnd <= rnd + 4'd1;
          if (rnd == 4'd15) begin
            plaintext <= pt_val;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed and round-trip bench for des_decrypt_core; ciphertexts for the
// random sweep come from a forward-schedule DES encryption model.

module tb_des_decrypt_core;
  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] key;
  logic [63:0] ciphertext;
  logic        busy;
  logic        done;
  logic [63:0] plaintext;

  int checks;
  int errors;
  logic [63:0] last_pt;

  des_decrypt_core dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key(key),
    .ciphertext(ciphertext),
    .busy(busy),
    .done(done),
    .plaintext(plaintext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SB [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Forward DES encryption with the standard left-shift key schedule.
  function automatic logic [63:0] des_encrypt(input logic [63:0] k, input logic [63:0] p);
    logic [63:0] ip, pre, res;
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [31:0] l, r, t, sv, f;
    logic [47:0] kk, e;
    logic [5:0]  six;
    int          row, col;
    for (int i = 0; i < 64; i++) ip[63-i] = p[64-IP_T[i]];
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    l = ip[63:32];
    r = ip[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SH_T[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) kk[47-i] = cd[56-PC2_T[i]];
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ kk;
      for (int b = 0; b < 8; b++) begin
        six = e[47-6*b -: 6];
        row = {30'd0, six[5], six[0]};
        col = {28'd0, six[4:1]};
        sv[31-4*b -: 4] = 4'(SB[b][row*16+col]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sv[32-P_T[i]];
      t = l ^ f;
      l = r;
      r = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[63-i] = pre[64-FP_T[i]];
    return res;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called between edges; returns #1 after the accepting edge.
  task automatic launch(input logic [63:0] k, input logic [63:0] ct);
    key        = k;
    ciphertext = ct;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns #1 after the edge that raises done, i.e. inside the done cycle.
  task automatic wait_done(input logic [63:0] exp, input logic [63:0] prev,
                           input bit interfere, input string name);
    int n;
    bit hold_bad, busy_bad;
    n = 0;
    hold_bad = 1'b0;
    busy_bad = 1'b0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (plaintext !== prev) hold_bad = 1'b1;
      if (interfere) begin
        if (n < 14) begin
          start      = 1'($urandom_range(0, 1));
          key        = {$urandom, $urandom};
          ciphertext = {$urandom, $urandom};
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk({name, "_latency"}, 64'(n), 64'd16);
    chk({name, "_plaintext"}, plaintext, exp);
    chk({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({name, "_busy_in_flight"}, {63'd0, busy_bad}, 64'd0);
    chk({name, "_hold_prev"}, {63'd0, hold_bad}, 64'd0);
  endtask

  task automatic idle_check(input int cycles, input string name);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk(name, {63'd0, seen}, 64'd0);
  endtask

  typedef struct {
    logic [63:0] key;
    logic [63:0] ct;
    logic [63:0] pt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [63:0] k, p;
    checks = 0;
    errors = 0;
    vecs[0] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF};
    vecs[1] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787};
    vecs[2] = '{64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF};

    rst        = 1'b1;
    start      = 1'b0;
    key        = '0;
    ciphertext = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_plaintext", plaintext, 64'd0);
    idle_check(40, "reset_idle_no_done");
    last_pt = 64'd0;

    // Each vector is launched in the done cycle of the one before it.
    for (int i = 0; i < 4; i++) begin
      launch(vecs[i].key, vecs[i].ct);
      wait_done(vecs[i].pt, last_pt, 1'b0, $sformatf("vec%0d", i));
      last_pt = vecs[i].pt;
    end

    launch(vecs[0].key, vecs[0].ct);
    wait_done(vecs[0].pt, last_pt, 1'b1, "busy_interfere");
    last_pt = vecs[0].pt;
    idle_check(20, "interfere_no_extra_done");

    launch(vecs[1].key, vecs[1].ct);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_plaintext", plaintext, 64'd0);
    idle_check(30, "midrst_no_done");
    last_pt = 64'd0;
    launch(vecs[1].key, vecs[1].ct);
    wait_done(vecs[1].pt, last_pt, 1'b0, "after_midrst");
    last_pt = vecs[1].pt;

    @(negedge clk);
    rst        = 1'b1;
    start      = 1'b1;
    key        = vecs[0].key;
    ciphertext = vecs[0].ct;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", {63'd0, busy}, 64'd0);
    chk("rst_start_plaintext", plaintext, 64'd0);
    idle_check(20, "rst_start_no_done");
    last_pt = 64'd0;

    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom};
      p = {$urandom, $urandom};
      launch(k, des_encrypt(k, p));
      wait_done(p, last_pt, 1'b0, $sformatf("rt%0d", i));
      last_pt = p;
    end
    idle_check(20, "final_idle_no_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_decrypt_core.md
# des_decrypt_core

Iterative DES decryption engine: recovers one 64-bit plaintext block from a 64-bit ciphertext block and 64-bit key per FIPS 46-3, one Feistel round per clock. Counterpart of the encryption datapath. It reuses the team's eight combinational S-box modules (S1–S8, 6-bit in, 4-bit out, row = {in[5],in[0]}, column = in[4:1]) inside the f-function. It sits between the block-input register stage and the output/display logic with a start/busy/done handshake.

## Interface
- No parameters; DES widths are fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. Synchronous and active-high.
- start  in  1  request. Sampled only while busy=0.
- key  in  64  DES key, FIPS bit 1 = key[63]. Parity bits are ignored via PC-1.
- ciphertext  in  64  block to decrypt, FIPS bit 1 = ciphertext[63].
- busy  out  1  high while a block is in flight.
- done  out  1  one-cycle pulse; plaintext is valid from this cycle onward.
- plaintext  out  64  result register. Holds its value until the next completion.

## Operation
- States:
  - IDLE: busy=0.
  - ROUND: busy=1, 4-bit round counter rnd runs 0..15.
- IDLE to ROUND: on start=1. At that edge, capture:
  - {L,R} = IP(ciphertext)
  - {C,D} = PC1(key) (28+28 bits)
  - rnd=0, busy=1.
- key, ciphertext and start are ignored at every other edge. Inputs may change freely once start has been sampled.
- ROUND, each edge:
  - K = PC2(C_n,D_n), where C_n,D_n are the current C,D after this round's rotation.
  - L' = R.
  - R' = L XOR P(S(E(R) XOR K)).
  - S = S1..S8 applied to 6-bit slices of the 48-bit value, MSB slice to S1.
- Reverse key schedule:
  - rnd=0 uses PC2 of the loaded C,D unrotated. The total left shift of 28 is the identity, so this key equals K16.
  - For rnd=1..15, C and D each rotate right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 respectively, before PC2.
  - Implement this with a registered C,D updated each round plus a combinational pre-rotation for the current round. An equivalent structure is acceptable if the keys used are K16..K1 in order.
- At rnd=15, on the same edge as the last round:
  - plaintext <= FP({R',L'}). The swap undoes the final-round exchange.
  - done <= 1, busy <= 0, state goes to IDLE.
- All arithmetic is XOR and bit permutation only. There are no carries and no width growth.

## Timing
- Reset values: busy=0, done=0, plaintext=64'h0, state IDLE, rnd=0, L/R/C/D=0.
- Latency: start sampled at edge t means rounds occur at edges t+1..t+16. done is high for exactly one cycle, between edge t+16 and edge t+17. busy is high over the same span it takes to get there, from edge t to edge t+16.
- Throughput: one block per 17 cycles. A start asserted during the done cycle is accepted at edge t+17. No bubble is required beyond that.
- start while busy=1: ignored, not queued. The in-flight block is unaffected.
- start held high continuously: a new block begins each time the engine returns to IDLE.
- rst asserted mid-operation: at the next edge, return to the reset values above. No done pulse is produced and the partial result is discarded.
- rst and start high on the same edge: rst wins, and the engine stays IDLE.
- done is never asserted except by completing round 16.

## Test plan
- Reset check: hold rst 2 cycles, then release -> busy=0, done=0, plaintext=0. No done pulse for 40 idle cycles.
- Known vector: key=64'h133457799BBCDFF1, ciphertext=64'h85E813540F0AB405, one-cycle start -> done exactly 16 cycles after the start edge, plaintext=64'h0123456789ABCDEF.
- Second vector, back-to-back:
  - Stimulus: key=64'h0E329232EA6D0D73, ciphertext=64'h0000000000000000, start re-asserted in the done cycle of the previous test.
  - Response: accepted with no extra gap; plaintext=64'h8787878787878787.
  - The previous plaintext holds until this done.
- Busy interference:
  - Stimulus: during rounds of the first vector, pulse start and change key and ciphertext to random values.
  - Response: single done at the original time, plaintext=64'h0123456789ABCDEF.
- Reset mid-flight: assert rst at round 8 -> busy=0 next cycle, no done ever appears, plaintext=0. A fresh start afterwards decrypts correctly.
- Round-trip sweep: 200 random key/plaintext pairs, encrypted by a reference model, fed as ciphertext -> every output equals the original plaintext. Each done arrives exactly 16 cycles after its start edge.
